mem_dmem_responder: RTL
=======================

// Module: mem_dmem_responder
// PURPOSE
//  Data-memory responder for the MEM stage of the 5-stage pipeline. Accepts one load/store
//  per request, stalls the pipeline for a fixed latency, then returns formatted load data
//  for MEM_Data_in, which feeds the MEM/WB register. Holds byte-addressable RAM; little-endian.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM depth in 32-bit words (power of 2); word index = addr[..:2] mod DEPTH
//  LAT          2     wait cycles in BUSY (>=1)
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-low reset (0 = reset)
//  MEM_req       in   1   MEM-stage instruction is a load or store
//  MEM_we        in   1   1 = store, 0 = load
//  MEM_addr      in   32  byte address
//  MEM_wdata     in   32  store data (low bits used for byte/half)
//  MEM_size      in   2   00 byte, 01 half, 10/11 word
//  MEM_unsigned  in   1   1 = zero-extend load, 0 = sign-extend
//  MEM_stall     out  1   freeze IF..MEM and hold EX/MEM; bubble into MEM/WB
//  MEM_rdata     out  32  formatted load data (to MEM_Data_in)
//  MEM_rvalid    out  1   one-cycle pulse: access complete
//  MEM_misalign  out  1   one-cycle pulse with rvalid: access was misaligned, suppressed
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, cnt=0, MEM_rdata=0, MEM_rvalid=0, MEM_misalign=0,
//   captured request regs=0. RAM contents NOT reset.
//  FSM IDLE -> BUSY -> RESP -> IDLE.
//   IDLE: MEM_req=1 -> capture we/addr/wdata/size/unsigned, cnt=0, go BUSY. Otherwise stay.
//   BUSY: cnt++ each cycle; when cnt==LAT-1, perform access at that edge, go RESP.
//   RESP: MEM_rvalid=1 one cycle; go IDLE unconditionally. MEM_req seen in RESP belongs
//    to the same instruction (pipeline advances at this edge) and is ignored.
//  MEM_stall = (state==IDLE & MEM_req) | (state==BUSY). Combinational; 0 in RESP.
//   Each access stalls exactly 1+LAT cycles; pipeline advances on the RESP edge.
//  Captured request is used; input changes after acceptance have no effect.
//  Alignment: half needs addr[0]=0; word needs addr[1:0]=0. Byte always aligned.
//   Misaligned: no RAM write, MEM_rdata<=0, MEM_misalign=1 during RESP.
//  Store: byte enables from addr[1:0]/size: byte lane addr[1:0] <= wdata[7:0]; half lanes
//   {addr[1],0}+1..0 <= wdata[15:0]; word all lanes. MEM_rdata unchanged by stores.
//  Load: select byte/half by addr[1:0]; extend to 32 per MEM_unsigned; word passes through.
//   MEM_rdata registered at the access edge; holds until next load/misaligned completion.
//  Address wraps: word index = addr[log2(DEPTH)+1:2]; upper bits ignored.
//  Reset mid-access: FSM returns to IDLE immediately; no write occurs unless the access edge
//   has already passed; stall deasserts.
// TESTING
//  1 Store word 0xDEADBEEF @0x10, then load word @0x10 -> stall high 1+LAT cycles each,
//    rvalid pulses in RESP, MEM_rdata=0xDEADBEEF.
//  2 Load byte @0x13 signed/unsigned after test 1 -> 0xFFFFFFDE / 0x000000DE;
//    half @0x12 signed -> 0xFFFFDEAD.
//  3 Store byte 0x55 @0x11 then load word @0x10 -> 0xDEAD55EF (other lanes intact).
//  4 Load half @0x11 -> misalign=1 with rvalid, MEM_rdata=0, RAM unchanged; word @0x12 same.
//  5 Back-to-back: req held high across RESP and next cycle -> exactly two accesses,
//    one IDLE cycle with stall=1 re-accepting; no double access.
//  6 reset=0 during BUSY of a store -> stall=0, rvalid never pulses, later load shows old data;
//    address DEPTH_WORDS*4+0x10 aliases 0x10.

Source files
------------

// File: rtl/mem_dmem_responder.sv
// mem_dmem_responder: fixed-latency byte-addressable data RAM for the MEM stage.
// Stalls the pipeline for 1+LAT cycles per access and returns formatted load data.
module mem_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LAT         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_req,
  input  logic        MEM_we,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_wdata,
  input  logic [1:0]  MEM_size,
  input  logic        MEM_unsigned,
  output logic        MEM_stall,
  output logic [31:0] MEM_rdata,
  output logic        MEM_rvalid,
  output logic        MEM_misalign
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [31:0]   sh;
  logic [31:0]   ld_data;
  logic [31:0]   wsh;
  logic [3:0]    be;
  logic          mis;
  logic          last;
  logic          wr;
  logic          unused_addr;
  assign unused_addr = ^MEM_addr[31:AW+2];
  assign idx       = addr_q[AW+1:2];
  assign last      = cnt_q == CW'(LAT - 1);
  assign mis       = (size_q == 2'b01 & addr_q[0]) | (size_q[1] & |addr_q[1:0]);
  assign wr        = state_q == BUSY & last & we_q & ~mis;
  assign MEM_stall = (state_q == IDLE & MEM_req) | state_q == BUSY;
  assign sh        = ram_q[idx] >> {addr_q[1:0], 3'b000};
  assign ld_data   = size_q[1] ? sh :
                     size_q[0] ? {{16{~uns_q & sh[15]}}, sh[15:0]} :
                                 {{24{~uns_q & sh[7]}}, sh[7:0]};
  assign be        = size_q[1] ? 4'hF :
                     size_q[0] ? 4'b0011 << {addr_q[1], 1'b0} :
                                 4'b0001 << addr_q[1:0];
  assign wsh       = size_q[1] ? wdata_q :
                     size_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  // RAM is deliberately not reset; writes only happen on the BUSY access edge
  always_ff @(posedge clk)
    if (wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) ram_q[idx][8*i +: 8] <= wsh[8*i +: 8];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      MEM_rdata    <= '0;
      MEM_rvalid   <= 1'b0;
      MEM_misalign <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (MEM_req) begin
          we_q    <= MEM_we;
          addr_q  <= MEM_addr[AW+1:0];
          wdata_q <= MEM_wdata;
          size_q  <= MEM_size;
          uns_q   <= MEM_unsigned;
          cnt_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state_q      <= RESP;
            MEM_rvalid   <= 1'b1;
            MEM_misalign <= mis;
            if (mis) MEM_rdata <= '0;
            else if (!we_q) MEM_rdata <= ld_data;
          end
        end
        default: begin
          state_q      <= IDLE;
          MEM_rvalid   <= 1'b0;
          MEM_misalign <= 1'b0;
        end
      endcase
    end
endmodule
